spi_responder: RTL and testbench

- SPI mode-0 target peripheral that answers the bit-banged SPI master of the MC14500 wrapper.
- The master drives SCLK/SDO from scratch bits 6/7 and samples SDI.
- Provides an 8 x 8-bit register bank. Reg 0 drives a parallel output port, reg 1 reads a parallel input port, regs 2-7 are scratch.
- Sits on the same clk_i domain as the wrapper. All SPI pins are oversampled, so no SPI-clock domain exists.

---
 rtl/spi_responder.sv | 203 ++++++++++++++++++++
 tb/tb_spi_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_responder.sv
// SPI mode-0 target with an 8 x 8-bit register bank, fully oversampled on clk_i.
// Reg 0 drives out_port, reg 1 reads in_port, regs 2-7 are scratch.
module spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] in_port,
  output logic [7:0] out_port,
  output logic       wr_stb,
  output logic [2:0] wr_addr,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_n_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sclk_hist_r;
  logic                   armed_r;

  state_t     state_r,   state_nxt_s;
  logic [2:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0] rx_r,      rx_nxt_s;
  logic [7:0] tx_r,      tx_nxt_s;
  logic       rw_r,      rw_nxt_s;
  logic [2:0] addr_r,    addr_nxt_s;
  logic [7:0] regs_r [8];

  logic       sclk_s, cs_n_s, mosi_s, rise_s, fall_s;
  logic [7:0] rx_byte_s;
  logic [2:0] rd_addr_s;
  logic [7:0] rd_data_s;
  logic       wr_en_s;
  logic       wr_stb_nxt_s, frame_done_nxt_s, miso_nxt_s;

  assign sclk_s    = sclk_sync_r[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync_r[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_r[SYNC_STAGES-1];
  assign rise_s    = sclk_s & ~sclk_hist_r;
  assign fall_s    = ~sclk_s & sclk_hist_r;
  assign rx_byte_s = {rx_r[6:0], mosi_s};
  assign out_port  = regs_r[0];

  // Pin synchronizers plus sclk history for edge detection. cs_n resets to
  // "selected" so a frame already in progress at reset release is not armed.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_n_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_hist_r <= 1'b0;
      armed_r     <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      cs_n_sync_r <= {cs_n_sync_r[SYNC_STAGES-2:0], cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      sclk_hist_r <= sclk_s;
      armed_r     <= armed_r | cs_n_s;
    end
  end

  // Read-data mux: command byte's address in CMD, next address in DATA.
  always_comb begin
    if (state_r == ST_CMD) begin
      rd_addr_s = rx_byte_s[2:0];
    end else begin
      rd_addr_s = addr_r + 3'd1;
    end
    if (rd_addr_s == 3'd1) begin
      rd_data_s = in_port;
    end else begin
      rd_data_s = regs_r[rd_addr_s];
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt_s      = state_r;
    bit_cnt_nxt_s    = bit_cnt_r;
    rx_nxt_s         = rx_r;
    tx_nxt_s         = tx_r;
    rw_nxt_s         = rw_r;
    addr_nxt_s       = addr_r;
    wr_en_s          = 1'b0;
    wr_stb_nxt_s     = 1'b0;
    frame_done_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (armed_r && !cs_n_s) begin
          state_nxt_s   = ST_CMD;
          bit_cnt_nxt_s = 3'd0;
          rx_nxt_s      = 8'd0;
          tx_nxt_s      = 8'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (cs_n_s) begin
          state_nxt_s      = ST_IDLE;
          frame_done_nxt_s = 1'b1;
        end else if (rise_s) begin
          rx_nxt_s = rx_byte_s;
          if (bit_cnt_r == 3'd7) begin
            rw_nxt_s      = rx_byte_s[7];
            addr_nxt_s    = rx_byte_s[2:0];
            tx_nxt_s      = rd_data_s;
            bit_cnt_nxt_s = 3'd0;
            state_nxt_s   = ST_DATA;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          state_nxt_s = ST_CMD;
        end
      end
      ST_DATA: begin
        if (cs_n_s) begin
          state_nxt_s      = ST_IDLE;
          frame_done_nxt_s = 1'b1;
        end else if (rise_s) begin
          rx_nxt_s = rx_byte_s;
          if (bit_cnt_r == 3'd7) begin
            if (rw_r) begin
              if (addr_r != 3'd1) begin
                wr_en_s      = 1'b1;
                wr_stb_nxt_s = 1'b1;
              end else begin
                wr_en_s = 1'b0;
              end
            end else begin
              tx_nxt_s = rd_data_s;
            end
            addr_nxt_s    = addr_r + 3'd1;
            bit_cnt_nxt_s = 3'd0;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          end
        end else if (fall_s && (bit_cnt_r != 3'd0)) begin
          // The fall right after a load is skipped so the new MSB stays up.
          tx_nxt_s = {tx_r[6:0], 1'b0};
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if ((state_nxt_s == ST_DATA) && !rw_nxt_s) begin
      miso_nxt_s = tx_nxt_s[7];
    end else begin
      miso_nxt_s = 1'b0;
    end
  end

  // Frame state, shift registers, register bank and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      rx_r       <= 8'd0;
      tx_r       <= 8'd0;
      rw_r       <= 1'b0;
      addr_r     <= 3'd0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      wr_stb     <= 1'b0;
      wr_addr    <= 3'd0;
      frame_done <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= 8'd0;
      end
    end else begin
      state_r    <= state_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      rx_r       <= rx_nxt_s;
      tx_r       <= tx_nxt_s;
      rw_r       <= rw_nxt_s;
      addr_r     <= addr_nxt_s;
      miso       <= miso_nxt_s;
      miso_oe    <= armed_r & ~cs_n_s;
      wr_stb     <= wr_stb_nxt_s;
      frame_done <= frame_done_nxt_s;
      if (wr_en_s) begin
        regs_r[addr_r] <= rx_byte_s;
        wr_addr        <= addr_r;
      end
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: directed vector table, hand-written
// corner sequences and random frames checked against a register-bank model.
module tb_spi_responder;

  localparam int HALF = 6;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, wr_stb, frame_done;
  logic [7:0] in_port = 8'h00;
  logic [7:0] out_port;
  logic [2:0] wr_addr;

  spi_responder #(.SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .in_port(in_port), .out_port(out_port),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .frame_done(frame_done)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int stb_cnt = 0;
  int fd_cnt  = 0;
  logic [2:0] stb_q[$];

  logic [7:0] frame_b [8];
  logic [7:0] rx_b [8];
  logic [7:0] model_reg [8];

  typedef struct {
    int         n;
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] in_val;
    logic [7:0] exp_out;
    int         exp_stb;
    bit         chk_rd;
    logic [7:0] rd0, rd1;
  } vec_t;

  vec_t vecs[7];

  always @(negedge clk_i) begin
    if (rst_n) begin
      if (wr_stb) begin
        stb_cnt++;
        stb_q.push_back(wr_addr);
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = b[i];
      cyc(HALF);
      r = {r[6:0], miso};
      sclk = 1'b1;
      cyc(HALF);
      sclk = 1'b0;
    end
  endtask

  // Runs one complete frame and checks it against the register-bank model.
  task automatic do_frame(input int n);
    int         stb0, fd0, exp_n;
    logic       rw;
    logic [2:0] a;
    logic [7:0] rxv, expv;
    logic [2:0] exp_q[$];
    stb0 = stb_cnt;
    fd0  = fd_cnt;
    stb_q.delete();
    cs_n = 1'b0;
    cyc(HALF);
    check("miso_oe_sel", miso_oe, 1);
    for (int i = 0; i < n; i++) begin
      spi_byte(frame_b[i], 8, rxv);
      rx_b[i] = rxv;
    end
    cyc(HALF);
    cs_n = 1'b1;
    cyc(HALF);
    check("miso_oe_desel", miso_oe, 0);
    rw = frame_b[0][7];
    a  = frame_b[0][2:0];
    for (int i = 1; i < n; i++) begin
      if (rw) begin
        if (a != 3'd1) begin
          model_reg[a] = frame_b[i];
          exp_q.push_back(a);
        end
      end else begin
        expv = (a == 3'd1) ? in_port : model_reg[a];
        check("rd_byte", rx_b[i], expv);
      end
      a = a + 3'd1;
    end
    exp_n = exp_q.size();
    check("stb_count", stb_cnt - stb0, exp_n);
    for (int i = 0; i < exp_n && i < stb_q.size(); i++) begin
      check("wr_addr", stb_q[i], exp_q[i]);
    end
    check("frame_done", fd_cnt - fd0, 1);
    check("out_port", out_port, model_reg[0]);
  endtask

  initial begin
    logic [7:0] rxv;
    int         stb0, fd0;

    for (int i = 0; i < 8; i++) model_reg[i] = 8'h00;
    vecs[0] = '{2, 8'h80, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 1, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{2, 8'h01, 8'h00, 8'h00, 8'h00, 8'h3C, 8'hA5, 0, 1'b1, 8'h3C, 8'h00};
    vecs[2] = '{4, 8'h86, 8'h11, 8'h22, 8'h33, 8'h00, 8'h33, 3, 1'b0, 8'h00, 8'h00};
    vecs[3] = '{2, 8'h81, 8'hFF, 8'h00, 8'h00, 8'h3C, 8'h33, 0, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{2, 8'h01, 8'h00, 8'h00, 8'h00, 8'h96, 8'h33, 0, 1'b1, 8'h96, 8'h00};
    vecs[5] = '{3, 8'h87, 8'h5A, 8'hC3, 8'h00, 8'h00, 8'hC3, 2, 1'b0, 8'h00, 8'h00};
    vecs[6] = '{3, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC3, 0, 1'b1, 8'h5A, 8'hC3};

    // Reset state
    cyc(3);
    check("rst_out_port", out_port, 0);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    cyc(8);
    check("idle_miso_oe", miso_oe, 0);

    // Directed vector table
    for (int v = 0; v < 7; v++) begin
      frame_b[0] = vecs[v].b0;
      frame_b[1] = vecs[v].b1;
      frame_b[2] = vecs[v].b2;
      frame_b[3] = vecs[v].b3;
      in_port = vecs[v].in_val;
      stb0 = stb_cnt;
      do_frame(vecs[v].n);
      check("vec_out_port", out_port, vecs[v].exp_out);
      check("vec_stb", stb_cnt - stb0, vecs[v].exp_stb);
      if (vecs[v].chk_rd) begin
        check("vec_rd0", rx_b[1], vecs[v].rd0);
        if (vecs[v].n > 2) check("vec_rd1", rx_b[2], vecs[v].rd1);
      end
    end

    // Aborted write: full command plus five data bits
    stb0 = stb_cnt;
    fd0  = fd_cnt;
    cs_n = 1'b0;
    cyc(HALF);
    spi_byte(8'h82, 8, rxv);
    spi_byte(8'hFF, 5, rxv);
    cyc(HALF);
    cs_n = 1'b1;
    cyc(HALF);
    check("abort_stb", stb_cnt - stb0, 0);
    check("abort_fd", fd_cnt - fd0, 1);
    frame_b[0] = 8'h02;
    frame_b[1] = 8'h00;
    do_frame(2);
    check("abort_reg2", rx_b[1], 8'h00);

    // Reset during a write data byte
    frame_b[0] = 8'h84; frame_b[1] = 8'h12; do_frame(2);
    frame_b[0] = 8'h80; frame_b[1] = 8'h5C; do_frame(2);
    cs_n = 1'b0;
    cyc(HALF);
    spi_byte(8'h80, 8, rxv);
    spi_byte(8'hA5, 4, rxv);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_port", out_port, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_miso", miso, 0);
    check("mid_rst_miso_oe", miso_oe, 0);
    check("mid_rst_wr_stb", wr_stb, 0);
    check("mid_rst_frame_done", frame_done, 0);
    for (int i = 0; i < 8; i++) model_reg[i] = 8'h00;
    cyc(3);
    rst_n = 1'b1;
    cyc(HALF);
    stb0 = stb_cnt;
    fd0  = fd_cnt;
    spi_byte(8'h80, 8, rxv);
    spi_byte(8'hFF, 8, rxv);
    cyc(HALF);
    check("post_rst_stb", stb_cnt - stb0, 0);
    check("post_rst_out_port", out_port, 0);
    cs_n = 1'b1;
    cyc(HALF);
    check("post_rst_fd", fd_cnt - fd0, 0);
    frame_b[0] = 8'h83; frame_b[1] = 8'h77; do_frame(2);
    frame_b[0] = 8'h03; frame_b[1] = 8'h00; do_frame(2);
    check("rearm_reg3", rx_b[1], 8'h77);

    // Random frames against the model
    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) frame_b[i] = 8'($urandom);
      in_port = 8'($urandom);
      do_frame(n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
